// File: rtl/irq_vector_ctrl.sv
// Multi-source vectored interrupt controller between PC-next logic and the PC register.
// Latches request edges into pending, picks the lowest eligible index, redirects the PC and saves the return PC.
module irq_vector_ctrl #(
  parameter int NUM_IRQ    = 8,
  parameter int PC_WIDTH   = 32,
  parameter int VEC_BASE   = 500,
  parameter int VEC_STRIDE = 4,
  parameter int ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] pc_next,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  input  logic                global_en,
  input  logic                return_from_isr,
  input  logic                stall,
  output logic [PC_WIDTH-1:0] pc_next_final,
  output logic [PC_WIDTH-1:0] pc_save,
  output logic                save_en,
  output logic [NUM_IRQ-1:0]  irq_ack,
  output logic [ID_W-1:0]     active_id,
  output logic                in_isr
);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    ISR_INIT = 2'd1,
    ISR      = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [NUM_IRQ-1:0]  irq_prev;
  logic [NUM_IRQ-1:0]  pending;
  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  eligible;
  logic [NUM_IRQ-1:0]  ack_vec;
  logic [ID_W-1:0]     sel_id;
  logic [PC_WIDTH-1:0] vec_addr;

  assign rise     = irq & ~irq_prev;
  assign eligible = pending & irq_mask;
  assign ack_vec  = NUM_IRQ'(1) << active_id;
  assign vec_addr = PC_WIDTH'(VEC_BASE) + PC_WIDTH'(active_id) * PC_WIDTH'(VEC_STRIDE);
  assign pc_save  = pc_next;

  // Scan from the top so the lowest set index is the last (winning) assignment.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= NORMAL;
    else       state <= state_nx;
  end

  // stall freezes every transition; the one non-stalled ISR_INIT cycle is the only write/ack cycle.
  always_comb begin
    state_nx = state;
    case (state)
      NORMAL:   if (global_en && (|eligible) && !stall) state_nx = ISR_INIT;
      ISR_INIT: if (!stall) state_nx = ISR;
      ISR:      if (return_from_isr && !stall) state_nx = NORMAL;
      default:  state_nx = NORMAL;
    endcase
  end

  always_comb begin
    pc_next_final = pc_next;
    save_en       = 1'b0;
    irq_ack       = '0;
    in_isr        = 1'b0;
    if (!reset) begin
      case (state)
        ISR_INIT: begin
          pc_next_final = vec_addr;
          in_isr        = 1'b1;
          if (!stall) begin
            save_en = 1'b1;
            irq_ack = ack_vec;
          end
        end
        ISR:     in_isr = 1'b1;
        default: in_isr = 1'b0;
      endcase
    end
  end

  // A rise in the same cycle as its ack re-arms the bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev  <= '0;
      pending   <= '0;
      active_id <= '0;
    end else begin
      irq_prev <= irq;
      pending  <= (pending & ~irq_ack) | rise;
      if (state == NORMAL && state_nx == ISR_INIT) active_id <= sel_id;
    end
  end

endmodule

// File: doc/irq_vector_ctrl.md
Name: irq_vector_ctrl

Overview:
Multi-source successor to the single-line interrupt controller in the pipeline front end. It latches edge-triggered requests from NUM_IRQ sources into a pending register and applies per-source masking, a global enable and fixed priority. When an interrupt is taken, it redirects the PC to a per-source vector, emits a save strobe so the return PC is written to the register file, and acknowledges the serviced source. It sits between the PC-next logic and the PC register.

Parameters:
NUM_IRQ, 8, number of interrupt sources (1..32)
PC_WIDTH, 32, PC width in bits
VEC_BASE, 500, vector address of source 0
VEC_STRIDE, 4, address distance between consecutive vectors
ID_W, $clog2(NUM_IRQ) (minimum 1), width of the source index

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  reset
pc_next  in  PC_WIDTH  PC computed by the pipeline
irq  in  NUM_IRQ  raw request lines, edge-detected
irq_mask  in  NUM_IRQ  1 = source enabled
global_en  in  1  master interrupt enable
return_from_isr  in  1  one-cycle pulse: ISR return retired
stall  in  1  pipeline stall; freezes the FSM
pc_next_final  out  PC_WIDTH  PC to load
pc_save  out  PC_WIDTH  return PC for the register file
save_en  out  1  register-file write enable for pc_save
irq_ack  out  NUM_IRQ  one-hot acknowledge pulse
active_id  out  ID_W  index of the source being serviced
in_isr  out  1  high while in ISR_INIT or ISR

Behaviour:
- Reset: synchronous, active-high. Clears state to NORMAL and clears pending, irq_prev, active_id, save_en and irq_ack. While reset is held, pc_next_final = pc_next and in_isr = 0.
- Edge detect: the rise vector is irq & ~irq_prev, and irq_prev <= irq every cycle. A line held high across reset release counts as one edge in the first cycle after reset.
- Pending: for each bit, pending <= (pending & ~clr) | rise, where clr is that bit's irq_ack. A new rise in the same cycle as its ack wins, so the bit stays set. Masked sources still latch pending.
- Eligible vector: pending & irq_mask. Priority is fixed; the lowest index wins. sel_id is the index of the winning bit.
- NORMAL: if global_en and the eligible vector is non-zero and stall = 0, go to ISR_INIT and register active_id <= sel_id.
- ISR_INIT (exactly one non-stalled cycle):
  - pc_next_final = VEC_BASE + active_id*VEC_STRIDE, truncated to PC_WIDTH.
  - save_en = 1 and pc_save = pc_next.
  - irq_ack = one-hot(active_id), which clears that pending bit at the clock edge.
  - Then go to ISR.
  - If stall = 1: hold ISR_INIT, keep the redirect asserted, and hold save_en = 0 and irq_ack = 0 until the first non-stalled cycle. Only that cycle writes and acks.
- ISR: pc_next_final = pc_next. On return_from_isr = 1 and stall = 0, go to NORMAL. No nesting: new requests only accumulate in pending.
- return_from_isr is ignored in NORMAL and ISR_INIT.
- After a return, the block spends at least one cycle in NORMAL before taking the next interrupt.
- Outputs in NORMAL and ISR: pc_next_final = pc_next, save_en = 0, irq_ack = 0.
- pc_save mirrors pc_next in every state.
- active_id holds its value until the next entry into ISR_INIT.
- irq_mask and global_en are sampled only in NORMAL. Changing them mid-ISR does not abort the ISR.
- Reset mid-ISR returns to NORMAL immediately and discards all pending requests.
- save_en and irq_ack are never high for more than one cycle per interrupt taken.

Test Plan:
1. Reset, then pulse irq[3] with mask = 8'hFF, global_en = 1 and pc_next = 100. Required: next cycle ISR_INIT with pc_next_final = 512, save_en = 1, pc_save = 100, irq_ack = 8'h08; pending[3] clears.
2. Rise on irq[5] and irq[2] in the same cycle. Required: source 2 is serviced first (vector 508). After return_from_isr, one cycle in NORMAL, then source 5 is serviced (vector 520).
3. irq[1] rises with mask[1] = 0. Required: no redirect. Setting mask[1] = 1 later takes the interrupt (vector 504).
4. Two-cycle stall in ISR_INIT. Required: pc_next_final = vector for all three cycles; save_en and irq_ack pulse only on the third cycle.
5. irq[0] re-rises in the same cycle as its ack. Required: pending[0] stays 1, and the interrupt is taken again after return.
6. Reset asserted in ISR with pending = 8'h30. Required: next cycle state NORMAL, pending = 0, in_isr = 0, pc_next_final = pc_next.
